// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared definitions for the nRisc control path.
//   - opcode values (ir[7:4])
//   - controller state encoding (3-bit)
//   - ALU function and PC source encodings, also used by the ALU and PC blocks
//   - ctrl_t: bundle of every control output produced by controle_decode
package nrisc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_LI   = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_J    = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_SLT    = 3'd4,
    ALU_PASS_B = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,  // pc + 1
    PC_REL = 2'd1,  // pc + 1 + sext(ir[3:0])
    PC_ABS = 2'd2   // {4'b0, ir[3:0]}
  } pc_src_t;

  typedef struct packed {
    logic    in1;
    logic    in2;
    logic    inec;
    logic    escreve_reg;
    alu_op_t alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    ir_write;
    logic    pc_write;
    pc_src_t pc_src;
    logic    halted;
    logic    illegal;
  } ctrl_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SLT);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hB) && (op <= 4'hE);
  endfunction

  // ALU function for the execute phase of each opcode. LI and the memory
  // ops use PASS_B: LI passes the immediate, LW/SW pass rb as the address.
  function automatic alu_op_t alu_for(input logic [3:0] op);
    case (op)
      OP_SUB:               return ALU_SUB;
      OP_AND:               return ALU_AND;
      OP_OR:                return ALU_OR;
      OP_SLT:               return ALU_SLT;
      OP_LI, OP_LW, OP_SW:  return ALU_PASS_B;
      OP_BEQ:               return ALU_SUB;
      default:              return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// unidade_controle_if: instruction/data memory handshake between the control
// unit (master) and the memory (slave).
//   instr     memory -> ctrl  instruction word, valid with mem_ready in FETCH
//   mem_ready memory -> ctrl  access completes on a posedge where this is 1
//   MemRead   ctrl -> memory  read strobe
//   MemWrite  ctrl -> memory  write strobe
interface unidade_controle_if;
  logic [7:0] instr;
  logic       mem_ready;
  logic       MemRead;
  logic       MemWrite;

  modport master (
    input  instr,
    input  mem_ready,
    output MemRead,
    output MemWrite
  );

  modport slave (
    output instr,
    output mem_ready,
    input  MemRead,
    input  MemWrite
  );
endinterface

// File: rtl/controle_decode.sv
// controle_decode: purely combinational map from (state, ir, zero, mem_ready)
// to every control output of the nRisc control unit.
//   state     in  current controller state
//   ir        in  latched instruction
//   zero      in  ALU zero flag (used by BEQ in EXEC)
//   mem_ready in  memory handshake (qualifies the FETCH load strobes)
//   ctrl      out all control outputs as one struct
module controle_decode
  import nrisc_pkg::*;
(
  input  state_t     state,
  input  logic [7:0] ir,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  logic [3:0] op;
  logic       unused_ir_bits;

  assign op = ir[7:4];
  // The immediate bits are consumed by the datapath, not by the controller.
  assign unused_ir_bits = ^ir[1:0];

  always_comb begin
    ctrl = '0;

    // Read selects depend on ir only, so they are stable from DECODE until
    // the next IR load and the register file's negedge read sees them early.
    // BEQ always compares r0 against r1.
    if (op == OP_BEQ) begin
      ctrl.in1 = 1'b0;
      ctrl.in2 = 1'b1;
    end else begin
      ctrl.in1 = ir[3];
      ctrl.in2 = ir[2];
    end
    ctrl.inec = ir[3];

    case (state)
      ST_FETCH: begin
        ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_INC;
        end
      end

      ST_DECODE: begin
        ctrl.illegal = is_illegal(op);
        if (op == OP_J) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_ABS;
        end
      end

      ST_EXEC: begin
        ctrl.alu_op  = alu_for(op);
        ctrl.alu_src = (op == OP_LI);
        if ((op == OP_BEQ) && zero) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_REL;
        end
      end

      // ALU controls are held through MEM and WB so the address / result
      // stays valid without a separate ALU output register.
      ST_MEM: begin
        ctrl.alu_op    = alu_for(op);
        ctrl.alu_src   = (op == OP_LI);
        ctrl.mem_read  = (op == OP_LW);
        ctrl.mem_write = (op == OP_SW);
      end

      ST_WB: begin
        ctrl.alu_op      = alu_for(op);
        ctrl.alu_src     = (op == OP_LI);
        ctrl.escreve_reg = 1'b1;
        ctrl.mem_to_reg  = (op == OP_LW);
      end

      ST_HALT: begin
        ctrl.halted = 1'b1;
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle control unit for the nRisc core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, latches the fetched instruction and
// drives the register file, ALU, memory and PC controls.
//   clock       in   system clock (register file writes posedge, reads negedge)
//   reset_n     in   asynchronous active-low reset
//   mem         if   memory handshake (instr, mem_ready, MemRead, MemWrite)
//   zero        in   ALU zero flag, sampled in EXEC
//   in1/in2     out  register file read selects A/B
//   inec        out  register file write select
//   EscreveReg  out  register file write enable
//   AluOp       out  ALU function
//   AluSrc      out  ALU B source (0 reg B, 1 sext immediate)
//   MemToReg    out  write-back source (1 memory, 0 ALU)
//   IRWrite     out  instruction register load
//   PCWrite     out  PC load enable
//   PCSrc       out  PC source select
//   halted      out  high in HALT
//   illegal     out  one-cycle pulse in DECODE on an undefined opcode
module unidade_controle
  import nrisc_pkg::*;
#(
  parameter logic [7:0] RESET_IR = 8'h00
) (
  input  logic                clock,
  input  logic                reset_n,
  unidade_controle_if.master  mem,
  input  logic                zero,
  output logic                in1,
  output logic                in2,
  output logic                inec,
  output logic                EscreveReg,
  output logic [2:0]          AluOp,
  output logic                AluSrc,
  output logic                MemToReg,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic [1:0]          PCSrc,
  output logic                halted,
  output logic                illegal
);

  state_t     state_reg;
  state_t     state_next;
  logic [7:0] ir_reg;
  logic [3:0] op;
  ctrl_t      ctrl_raw;
  ctrl_t      ctrl_out;

  assign op = ir_reg[7:4];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_FETCH;
      ir_reg    <= RESET_IR;
    end else begin
      state_reg <= state_next;
      if (ctrl_raw.ir_write) begin
        ir_reg <= mem.instr;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH: begin
        if (mem.mem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (op == OP_HALT)
          state_next = ST_HALT;
        else if ((op == OP_NOP) || (op == OP_J) || is_illegal(op))
          state_next = ST_FETCH;
        else
          state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_rtype(op) || (op == OP_LI))
          state_next = ST_WB;
        else if ((op == OP_LW) || (op == OP_SW))
          state_next = ST_MEM;
        else
          state_next = ST_FETCH;
      end
      ST_MEM: begin
        if (mem.mem_ready)
          state_next = (op == OP_LW) ? ST_WB : ST_FETCH;
      end
      ST_WB:   state_next = ST_FETCH;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  controle_decode u_decode (
    .state     (state_reg),
    .ir        (ir_reg),
    .zero      (zero),
    .mem_ready (mem.mem_ready),
    .ctrl      (ctrl_raw)
  );

  // While reset is held every output is forced low, so a stalled store is
  // abandoned the instant reset_n falls rather than at the next edge.
  always_comb begin
    ctrl_out = ctrl_raw;
    if (!reset_n) ctrl_out = '0;
  end

  assign in1          = ctrl_out.in1;
  assign in2          = ctrl_out.in2;
  assign inec         = ctrl_out.inec;
  assign EscreveReg   = ctrl_out.escreve_reg;
  assign AluOp        = ctrl_out.alu_op;
  assign AluSrc       = ctrl_out.alu_src;
  assign mem.MemRead  = ctrl_out.mem_read;
  assign mem.MemWrite = ctrl_out.mem_write;
  assign MemToReg     = ctrl_out.mem_to_reg;
  assign IRWrite      = ctrl_out.ir_write;
  assign PCWrite      = ctrl_out.pc_write;
  assign PCSrc        = ctrl_out.pc_src;
  assign halted       = ctrl_out.halted;
  assign illegal      = ctrl_out.illegal;

endmodule
